// File: rtl/mcpu_alu_pkg.sv
// Shared opcode encodings and default widths for the mcpu ALU.
package mcpu_alu_pkg;

    localparam int CMD_SIZE_DEF  = 2;
    localparam int WORD_SIZE_DEF = 8;

    localparam int CMD_AND = 0;
    localparam int CMD_OR  = 1;
    localparam int CMD_XOR = 2;
    localparam int CMD_ADD = 3;

endpackage

// File: rtl/mcpu_alu_core.sv
// Combinational result and carry generation for the mcpu ALU.
module mcpu_alu_core
    import mcpu_alu_pkg::*;
#(
    parameter int CMD_SIZE  = CMD_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 carry
);

    logic [WORD_SIZE:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        // Any opcode outside the logic ops decodes as ADD.
        case (opcode)
            CMD_SIZE'(CMD_AND): result = a & b;
            CMD_SIZE'(CMD_OR):  result = a | b;
            CMD_SIZE'(CMD_XOR): result = a ^ b;
            default: begin
                result = sum[WORD_SIZE-1:0];
                carry  = sum[WORD_SIZE];
            end
        endcase
    end

endmodule

// File: rtl/mcpu_alu.sv
// Registered one-cycle ALU; define MCPU_ALU_FLAGS_EN to add ZERO/NEGATIVE.
module mcpu_alu
    import mcpu_alu_pkg::*;
#(
    parameter int CMD_SIZE  = CMD_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic [WORD_SIZE-1:0] out,
    output logic                 OVERFLOW,
    output logic                 out_valid
`ifdef MCPU_ALU_FLAGS_EN
    ,
    output logic                 ZERO,
    output logic                 NEGATIVE
`endif
);

    logic [WORD_SIZE-1:0] res;
    logic                 carry;

    logic [WORD_SIZE-1:0] out_d, out_q;
    logic                 ovf_d, ovf_q;
    logic                 vld_d, vld_q;

    mcpu_alu_core #(
        .CMD_SIZE  (CMD_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_core (
        .opcode (opcode),
        .a      (r1),
        .b      (r2),
        .result (res),
        .carry  (carry)
    );

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        vld_d = in_valid;
        if (in_valid) begin
            out_d = res;
            ovf_d = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign OVERFLOW  = ovf_q;
    assign out_valid = vld_q;

`ifdef MCPU_ALU_FLAGS_EN
    logic zero_d, zero_q;
    logic neg_d, neg_q;

    always_comb begin
        zero_d = (out_d == '0);
        neg_d  = out_d[WORD_SIZE-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign ZERO     = zero_q;
    assign NEGATIVE = neg_q;
`endif

endmodule

// File: tb/tb_mcpu_alu.sv
// Directed and random-stream bench for mcpu_alu.
module tb_mcpu_alu;
    import mcpu_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] opcode = 2'd0;
    logic [7:0] r1 = 8'd0;
    logic [7:0] r2 = 8'd0;
    logic [7:0] out;
    logic       OVERFLOW;
    logic       out_valid;
`ifdef MCPU_ALU_FLAGS_EN
    logic       ZERO;
    logic       NEGATIVE;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcpu_alu #(
        .CMD_SIZE  (2),
        .WORD_SIZE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .r1        (r1),
        .r2        (r2),
        .out       (out),
        .OVERFLOW  (OVERFLOW),
        .out_valid (out_valid)
`ifdef MCPU_ALU_FLAGS_EN
        ,
        .ZERO      (ZERO),
        .NEGATIVE  (NEGATIVE)
`endif
    );

    // Apply one cycle of stimulus and land 1ns after the sampling edge.
    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        opcode   = op;
        r1       = a;
        r2       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'd0 || OVERFLOW !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async out=%0d ovf=%b vld=%b want 0 0 0",
                     out, OVERFLOW, out_valid);
        end
        drive(1'b1, 2'd3, 8'd3, 8'd4);
        checks++;
        if (out !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out=%0d vld=%b want 0 0",
                     out, out_valid);
        end
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 8'd6, 8'd3);
        checks++;
        if (out !== 8'd2 || OVERFLOW !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge out=%0d ovf=%b vld=%b want 2 0 1",
                     out, OVERFLOW, out_valid);
        end
    endtask

    task automatic test_logic;
        logic [1:0] ops [3];
        logic [7:0] exp [3];
        ops = '{2'd0, 2'd1, 2'd2};
        exp = '{8'd5, 8'd5, 8'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 8'd5, 8'd5);
            checks++;
            if (out !== exp[i] || OVERFLOW !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL logic_op%0d out=%0d ovf=%b vld=%b want %0d 0 1",
                         ops[i], out, OVERFLOW, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_add;
        logic [7:0] a   [4];
        logic [7:0] b   [4];
        logic [7:0] exp [4];
        logic       ovf [4];
        a   = '{8'd5, 8'd0, 8'd200, 8'd255};
        b   = '{8'd5, 8'd0, 8'd100, 8'd1};
        exp = '{8'd10, 8'd0, 8'd44, 8'd0};
        ovf = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd3, a[i], b[i]);
            checks++;
            if (out !== exp[i] || OVERFLOW !== ovf[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL add_%0d+%0d out=%0d ovf=%b vld=%b want %0d %b 1",
                         a[i], b[i], out, OVERFLOW, out_valid, exp[i], ovf[i]);
            end
        end
    endtask

    task automatic test_hold;
        drive(1'b1, 2'd3, 8'd255, 8'd2);
        drive(1'b1, 2'd3, 8'd2, 8'd2);
        checks++;
        if (out !== 8'd4 || OVERFLOW !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load out=%0d ovf=%b vld=%b want 4 0 1",
                     out, OVERFLOW, out_valid);
        end
        drive(1'b0, 2'd3, 8'd7, 8'd2);
        checks++;
        if (out !== 8'd4 || OVERFLOW !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle out=%0d ovf=%b vld=%b want 4 0 0",
                     out, OVERFLOW, out_valid);
        end
        drive(1'b0, 2'd3, 8'd200, 8'd200);
        checks++;
        if (out !== 8'd4 || OVERFLOW !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle2 out=%0d ovf=%b vld=%b want 4 0 0",
                     out, OVERFLOW, out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 2'd3, 8'd1, 8'd1);
        checks++;
        if (out !== 8'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre out=%0d vld=%b want 2 1", out, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'd0 || OVERFLOW !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async out=%0d ovf=%b vld=%b want 0 0 0",
                     out, OVERFLOW, out_valid);
        end
        drive(1'b0, 2'd3, 8'd1, 8'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'd3, 8'd1, 8'd1);
            checks++;
            if (out !== 8'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_release%0d out=%0d vld=%b want 0 0",
                         i, out, out_valid);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [7:0] a, b, e_out;
        logic [8:0] s;
        logic       e_ovf;
        int         bad;
        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            s  = {1'b0, a} + {1'b0, b};
            e_ovf = 1'b0;
            if (op == 2'd0)      e_out = a & b;
            else if (op == 2'd1) e_out = a | b;
            else if (op == 2'd2) e_out = a ^ b;
            else begin
                e_out = s[7:0];
                e_ovf = s[8];
            end
            drive(1'b1, op, a, b);
            bad = 0;
            if (out !== e_out || OVERFLOW !== e_ovf || out_valid !== 1'b1) bad = 1;
`ifdef MCPU_ALU_FLAGS_EN
            if (ZERO !== (e_out == 8'd0) || NEGATIVE !== e_out[7]) bad = 1;
`endif
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%0d b=%0d out=%0d ovf=%b vld=%b want %0d %b 1",
                         i, op, a, b, out, OVERFLOW, out_valid, e_out, e_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
